// File: rtl/picobello_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | picobello_pkg                                                        |
// | Shared types and defaults for the cluster-tile DCA offload path.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package picobello_pkg;

  localparam int DCA_MAX_OUTSTANDING = 4;
  localparam int DCA_NUM_REQ         = 2;

  typedef logic [63:0] dca_router_req_t;
  typedef logic [63:0] dca_router_resp_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(DCA_NUM_REQ)-1:0] dca_req_idx_t;

endpackage
`default_nettype wire

// File: rtl/dca_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dca_tag_fifo                                                         |
// | Requester-index FIFO tracking in-flight DCA ops; no fall-through.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dca_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH-1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push writes into at the edge.
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/dca_offload_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dca_offload_arbiter                                                  |
// | Round-robin sharing of the DCA port with in-order response routing.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dca_offload_arbiter
  import picobello_pkg::*;
#(
  parameter int  NUM_REQ         = DCA_NUM_REQ,
  parameter int  MAX_OUTSTANDING = DCA_MAX_OUTSTANDING,
  parameter type dca_req_t       = dca_router_req_t,
  parameter type dca_rsp_t       = dca_router_resp_t
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic     [NUM_REQ-1:0]                req_valid_i,
  output logic     [NUM_REQ-1:0]                req_ready_o,
  input  dca_req_t [NUM_REQ-1:0]                req_data_i,
  output logic     [NUM_REQ-1:0]                rsp_valid_o,
  input  logic     [NUM_REQ-1:0]                rsp_ready_i,
  output dca_rsp_t                              rsp_data_o,
  output dca_req_t                              dca_req_o,
  output logic                                  dca_req_valid_o,
  input  logic                                  dca_req_ready_i,
  input  dca_rsp_t                              dca_rsp_i,
  input  logic                                  dca_rsp_valid_i,
  output logic                                  dca_rsp_ready_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
  output logic                                  err_unexpected_o
);

  localparam int c_IDX_W = idx_width(NUM_REQ);

  typedef logic [c_IDX_W-1:0] idx_t;

  idx_t r_rr_ptr;
  idx_t r_locked_idx;
  logic r_lock;
  logic r_err;
  idx_t w_sel;
  idx_t w_head;
  logic w_any;
  logic w_full;
  logic w_empty;
  logic w_req_hs;
  logic w_rsp_hs;

  function automatic idx_t rr_idx(input idx_t base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return idx_t'(s);
  endfunction

  // A stalled grant stays with its requester until the handshake completes.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    if (r_lock) begin
      w_any = req_valid_i[r_locked_idx];
      w_sel = r_locked_idx;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_any && req_valid_i[rr_idx(r_rr_ptr, k)]) begin
          w_any = 1'b1;
          w_sel = rr_idx(r_rr_ptr, k);
        end
      end
    end
  end

  assign dca_req_valid_o = ~rst_i & ~w_full & w_any;
  assign dca_req_o       = req_data_i[w_sel];
  assign w_req_hs        = dca_req_valid_o & dca_req_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (dca_req_valid_o) req_ready_o[w_sel] = dca_req_ready_i;
  end

  // With nothing in flight a response is swallowed and flagged.
  always_comb begin
    rsp_valid_o     = '0;
    dca_rsp_ready_o = 1'b0;
    if (!rst_i) begin
      if (w_empty) begin
        dca_rsp_ready_o = 1'b1;
      end else begin
        rsp_valid_o[w_head] = dca_rsp_valid_i;
        dca_rsp_ready_o     = rsp_ready_i[w_head];
      end
    end
  end

  assign w_rsp_hs         = dca_rsp_valid_i & dca_rsp_ready_o & ~w_empty;
  assign rsp_data_o       = dca_rsp_i;
  assign err_unexpected_o = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock       <= 1'b0;
      r_locked_idx <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_lock <= 1'b0;
      end else if (dca_req_valid_o) begin
        r_lock       <= 1'b1;
        r_locked_idx <= w_sel;
      end
      if (w_empty && dca_rsp_valid_i) r_err <= 1'b1;
    end
  end

  if (NUM_REQ > 1) begin : g_rr
    always_ff @(posedge clk_i) begin
      if (rst_i)         r_rr_ptr <= '0;
      else if (w_req_hs) r_rr_ptr <= rr_idx(w_sel, 1);
    end
  end else begin : g_rr_fixed
    assign r_rr_ptr = '0;
  end

  dca_tag_fifo #(
    .WIDTH (c_IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (w_req_hs),
    .i_data  (w_sel),
    .i_pop   (w_rsp_hs),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding_o)
  );

  a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    r_lock |-> req_valid_i[r_locked_idx]);

endmodule
`default_nettype wire
